// File: rtl/rtob_pkg.sv
// rtob_pkg: shared constants and types for the real-time output buffer.
//   RTOB_TS_W / RTOB_DATA_W   default timestamp / payload widths
//   RTOB_DEPTH / RTOB_THRESHOLD default FIFO depth and full threshold
//   RTOB_LATE_W               width of the saturating late-discard counter
//   rtob_entry_t              packed {ts, data} entry at default widths
package rtob_pkg;
  localparam int RTOB_TS_W      = 64;
  localparam int RTOB_DATA_W    = 8;
  localparam int RTOB_DEPTH     = 1024;
  localparam int RTOB_THRESHOLD = 1000;
  localparam int RTOB_LATE_W    = 16;

  typedef struct packed {
    logic [RTOB_TS_W-1:0]   ts;
    logic [RTOB_DATA_W-1:0] data;
  } rtob_entry_t;
endpackage

// File: rtl/rtob_core_param_if.sv
// rtob_core_param_if: bundles the control, data and status signals of
// rtob_core_param. modport master drives requests (testbench / system),
// modport slave is the buffer core.
//
// Handshake: write is a single-cycle request with no ready. Every cycle
// write=1 either pushes fifo_din, merges it into the tail entry, or (when
// full) drops it and pulses overflow_error on the next cycle. Output events
// (counter_matched, timestamp_error, overflow_error) are one-cycle pulses
// with their data held in the companion *_data / rto_out registers.
interface rtob_core_param_if
  import rtob_pkg::*;
#(
  parameter int TS_WIDTH   = RTOB_TS_W,
  parameter int DATA_WIDTH = RTOB_DATA_W,
  parameter int DEPTH      = RTOB_DEPTH
);
  localparam int EW = TS_WIDTH + DATA_WIDTH;
  localparam int LW = $clog2(DEPTH + 1);

  logic                   auto_start;
  logic                   flush;
  logic                   write;
  logic [EW-1:0]          fifo_din;
  logic [TS_WIDTH-1:0]    counter;
  logic                   err_clear;
  logic [EW-1:0]          rto_out;
  logic                   counter_matched;
  logic                   timestamp_error;
  logic                   overflow_error;
  logic [EW-1:0]          timestamp_error_data;
  logic [EW-1:0]          overflow_error_data;
  logic                   ts_err_sticky;
  logic                   ovf_err_sticky;
  logic [RTOB_LATE_W-1:0] late_count;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;

  modport master (
    output auto_start, flush, write, fifo_din, counter, err_clear,
    input  rto_out, counter_matched, timestamp_error, overflow_error,
           timestamp_error_data, overflow_error_data, ts_err_sticky,
           ovf_err_sticky, late_count, full, empty, level
  );

  modport slave (
    input  auto_start, flush, write, fifo_din, counter, err_clear,
    output rto_out, counter_matched, timestamp_error, overflow_error,
           timestamp_error_data, overflow_error_data, ts_err_sticky,
           ovf_err_sticky, late_count, full, empty, level
  );
endinterface

// File: rtl/rtob_sync_fifo.sv
// rtob_sync_fifo: show-ahead synchronous FIFO storage.
//   clk, reset    clock / synchronous active-high reset
//   i_flush       clears pointers and level (contents left as-is)
//   i_push/i_din  append an entry (caller guarantees not full)
//   i_pop         drop head entry (caller guarantees not empty)
//   i_tail_we/i_tail_din  overwrite the most recently pushed entry
//   o_head        head entry, valid combinationally while level != 0
//   o_level       occupancy
module rtob_sync_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  input  logic                       i_tail_we,
  input  logic [WIDTH-1:0]           i_tail_din,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Storage is not reset; only pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end else if (i_tail_we) begin
      r_mem[r_wr_ptr - AW'(1)] <= i_tail_din;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

// File: rtl/rtob_core_param.sv
// rtob_core_param: timestamp-ordered release buffer. Entries {ts, payload}
// are queued; while auto_start is high the head is compared against the
// free-running counter and released on equality or discarded when late.
//   clk, reset  clock / synchronous active-high reset
//   bus         rtob_core_param_if.slave (requests, outputs, status)
// Optional feature: define RTOB_MERGE_SAME_TS_EN to merge a write carrying
// the same timestamp as the last accepted write into the queued tail entry.
module rtob_core_param
  import rtob_pkg::*;
#(
  parameter int TS_WIDTH   = RTOB_TS_W,
  parameter int DATA_WIDTH = RTOB_DATA_W,
  parameter int DEPTH      = RTOB_DEPTH,
  parameter int THRESHOLD  = RTOB_THRESHOLD
) (
  input logic              clk,
  input logic              reset,
  rtob_core_param_if.slave bus
);
  localparam int EW = TS_WIDTH + DATA_WIDTH;
  localparam int LW = $clog2(DEPTH + 1);

  logic [EW-1:0]          w_head;
  logic [TS_WIDTH-1:0]    w_head_ts;
  logic [LW-1:0]          w_level;
  logic                   w_empty, w_full, w_active;
  logic                   w_match, w_late, w_pop;
  logic                   w_merge, w_push, w_ovf;

  logic [EW-1:0]          r_rto, r_ts_data, r_ovf_data;
  logic                   r_matched, r_ts_err, r_ovf_err;
  logic                   r_ts_sticky, r_ovf_sticky;
  logic [RTOB_LATE_W-1:0] r_late_cnt;

  assign w_head_ts = w_head[EW-1:DATA_WIDTH];
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level >= LW'(THRESHOLD));

  // Flush suppresses pops along with writes.
  assign w_active = bus.auto_start & ~w_empty & ~bus.flush;
  assign w_match  = w_active & (w_head_ts == bus.counter);
  assign w_late   = w_active & (bus.counter > w_head_ts);
  assign w_pop    = w_match | w_late;

`ifdef RTOB_MERGE_SAME_TS_EN
  logic [TS_WIDTH-1:0] r_last_ts;
  logic                r_last_valid;

  // While the queue is non-empty the last accepted write is the tail entry;
  // it is unsafe to merge only if that same entry is leaving this cycle.
  assign w_merge = bus.write & ~bus.flush & r_last_valid & ~w_empty &
                   (bus.fifo_din[EW-1:DATA_WIDTH] == r_last_ts) &
                   ~(w_pop & (w_level == LW'(1)));

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_last_valid <= 1'b0;
      r_last_ts    <= '0;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last_ts    <= bus.fifo_din[EW-1:DATA_WIDTH];
    end
  end
`else
  assign w_merge = 1'b0;
`endif

  assign w_push = bus.write & ~bus.flush & ~w_merge & ~w_full;
  assign w_ovf  = bus.write & ~bus.flush & ~w_merge &  w_full;

  rtob_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (bus.flush),
    .i_push     (w_push),
    .i_din      (bus.fifo_din),
    .i_pop      (w_pop),
    .i_tail_we  (w_merge),
    .i_tail_din (bus.fifo_din),
    .o_head     (w_head),
    .o_level    (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rto        <= '0;
      r_ts_data    <= '0;
      r_ovf_data   <= '0;
      r_matched    <= 1'b0;
      r_ts_err     <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_ts_sticky  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_late_cnt   <= '0;
    end else begin
      r_matched <= w_match;
      r_ts_err  <= w_late;
      r_ovf_err <= w_ovf;
      if (w_match) r_rto      <= w_head;
      if (w_late)  r_ts_data  <= w_head;
      if (w_ovf)   r_ovf_data <= bus.fifo_din;
      // A clear coinciding with a new error leaves that error recorded.
      if (bus.err_clear) begin
        r_ts_sticky  <= w_late;
        r_ovf_sticky <= w_ovf;
        r_late_cnt   <= w_late ? RTOB_LATE_W'(1) : '0;
      end else begin
        if (w_late) r_ts_sticky  <= 1'b1;
        if (w_ovf)  r_ovf_sticky <= 1'b1;
        if (w_late && (r_late_cnt != '1)) r_late_cnt <= r_late_cnt + RTOB_LATE_W'(1);
      end
    end
  end

  assign bus.rto_out              = r_rto;
  assign bus.counter_matched      = r_matched;
  assign bus.timestamp_error      = r_ts_err;
  assign bus.overflow_error       = r_ovf_err;
  assign bus.timestamp_error_data = r_ts_data;
  assign bus.overflow_error_data  = r_ovf_data;
  assign bus.ts_err_sticky        = r_ts_sticky;
  assign bus.ovf_err_sticky       = r_ovf_sticky;
  assign bus.late_count           = r_late_cnt;
  assign bus.full                 = w_full;
  assign bus.empty                = w_empty;
  assign bus.level                = w_level;
endmodule

// File: tb/tb_rtob_core_param.sv
// tb_rtob_core_param: directed bench for rtob_core_param. One instance at
// default size (1024/1000) and one small instance (8/6) for wrap-around.
module tb_rtob_core_param;
  import rtob_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtob_core_param_if #(.TS_WIDTH(RTOB_TS_W), .DATA_WIDTH(RTOB_DATA_W),
                       .DEPTH(RTOB_DEPTH)) b_if ();
  rtob_core_param #(.TS_WIDTH(RTOB_TS_W), .DATA_WIDTH(RTOB_DATA_W),
                    .DEPTH(RTOB_DEPTH), .THRESHOLD(RTOB_THRESHOLD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  rtob_core_param_if #(.TS_WIDTH(RTOB_TS_W), .DATA_WIDTH(RTOB_DATA_W),
                       .DEPTH(8)) s_if ();
  rtob_core_param #(.TS_WIDTH(RTOB_TS_W), .DATA_WIDTH(RTOB_DATA_W),
                    .DEPTH(8), .THRESHOLD(6)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if)
  );

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [71:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input logic [63:0] ts, input logic [7:0] d);
    rtob_entry_t e;
    e.ts   = ts;
    e.data = d;
    return e;
  endfunction

  initial begin
    b_if.auto_start = 0; b_if.flush = 0; b_if.write = 0; b_if.err_clear = 0;
    b_if.fifo_din = '0; b_if.counter = '0;
    s_if.auto_start = 0; s_if.flush = 0; s_if.write = 0; s_if.err_clear = 0;
    s_if.fifo_din = '0; s_if.counter = '0;
    reset = 1;
    step(); step();
    reset = 0;

    chk("rst_level", b_if.level, 0);
    chk("rst_empty", b_if.empty, 1);
    chk("rst_full", b_if.full, 0);
    chk("rst_rto", b_if.rto_out, 0);
    chk("rst_late", b_if.late_count, 0);
    chk("rst_small_level", s_if.level, 0);

    // match: ts=100 released when counter reaches 100
    b_if.auto_start = 1; b_if.counter = 99;
    b_if.fifo_din = mk(100, 8'hA5); b_if.write = 1;
    step();
    b_if.write = 0;
    chk("push_level", b_if.level, 1);
    chk("push_empty", b_if.empty, 0);
    chk("early_no_match", b_if.counter_matched, 0);
    b_if.counter = 100;
    step();
    chk("match_pulse", b_if.counter_matched, 1);
    chk("match_rto", b_if.rto_out, mk(100, 8'hA5));
    chk("match_empty", b_if.empty, 1);
    step();
    chk("match_pulse_end", b_if.counter_matched, 0);

    // late discard with auto_start gating first
    b_if.auto_start = 0; b_if.counter = 60;
    b_if.fifo_din = mk(50, 8'h11); b_if.write = 1;
    step();
    b_if.write = 0;
    step();
    chk("no_auto_level", b_if.level, 1);
    chk("no_auto_err", b_if.timestamp_error, 0);
    b_if.auto_start = 1;
    step();
    chk("late_pulse", b_if.timestamp_error, 1);
    chk("late_data", b_if.timestamp_error_data, mk(50, 8'h11));
    chk("late_cnt", b_if.late_count, 1);
    chk("late_sticky", b_if.ts_err_sticky, 1);
    chk("late_rto_held", b_if.rto_out, mk(100, 8'hA5));
    chk("late_no_match", b_if.counter_matched, 0);
    step();
    chk("late_pulse_end", b_if.timestamp_error, 0);
    b_if.err_clear = 1;
    step();
    b_if.err_clear = 0;
    chk("clr_sticky", b_if.ts_err_sticky, 0);
    chk("clr_cnt", b_if.late_count, 0);

    // clear coinciding with a new late: new error wins
    b_if.auto_start = 0;
    b_if.fifo_din = mk(10, 8'h01); b_if.write = 1;
    step();
    b_if.fifo_din = mk(20, 8'h02);
    step();
    b_if.write = 0; b_if.auto_start = 1;
    step();
    chk("late2_cnt", b_if.late_count, 1);
    chk("late2_data", b_if.timestamp_error_data, mk(10, 8'h01));
    b_if.err_clear = 1;
    step();
    b_if.err_clear = 0;
    chk("clr_win_cnt", b_if.late_count, 1);
    chk("clr_win_sticky", b_if.ts_err_sticky, 1);
    chk("clr_win_data", b_if.timestamp_error_data, mk(20, 8'h02));

    // same-timestamp writes
    b_if.auto_start = 0;
    b_if.fifo_din = mk(200, 8'h01); b_if.write = 1;
    step();
    b_if.fifo_din = mk(200, 8'h02);
    step();
    b_if.write = 0;
`ifdef RTOB_MERGE_SAME_TS_EN
    chk("merge_level", b_if.level, 1);
`else
    chk("merge_level", b_if.level, 2);
`endif
    b_if.counter = 200; b_if.auto_start = 1;
    step();
    chk("merge_match1", b_if.counter_matched, 1);
`ifdef RTOB_MERGE_SAME_TS_EN
    chk("merge_rto1", b_if.rto_out, mk(200, 8'h02));
    step();
    chk("merge_match2", b_if.counter_matched, 0);
`else
    chk("merge_rto1", b_if.rto_out, mk(200, 8'h01));
    step();
    chk("merge_match2", b_if.counter_matched, 1);
    chk("merge_rto2", b_if.rto_out, mk(200, 8'h02));
`endif
    step();
    chk("merge_empty", b_if.empty, 1);

    // flush with simultaneous write
    b_if.auto_start = 0;
    for (int i = 0; i < 5; i++) begin
      b_if.fifo_din = mk(64'(300 + i), 8'(i)); b_if.write = 1;
      step();
    end
    b_if.write = 0;
    chk("pre_flush_level", b_if.level, 5);
    b_if.flush = 1; b_if.write = 1; b_if.fifo_din = mk(400, 8'h09);
    step();
    b_if.flush = 0; b_if.write = 0;
    chk("flush_level", b_if.level, 0);
    chk("flush_empty", b_if.empty, 1);
    chk("flush_sticky", b_if.ts_err_sticky, 1);
    chk("flush_late_cnt", b_if.late_count, 1);
    chk("flush_rto", b_if.rto_out, mk(200, 8'h02));
    step();
    chk("flush_wr_ignored", b_if.level, 0);

    // fill to threshold, then overflow
    for (int i = 0; i < 1000; i++) begin
      b_if.fifo_din = mk(64'(1000 + i), 8'(i)); b_if.write = 1;
      step();
      if (i == 998) begin
        chk("lvl999_full", b_if.full, 0);
        chk("lvl999_level", b_if.level, 999);
      end
    end
    chk("thr_level", b_if.level, 1000);
    chk("thr_full", b_if.full, 1);
    b_if.fifo_din = mk(5000, 8'h3C);
    step();
    b_if.write = 0;
    chk("ovf_pulse", b_if.overflow_error, 1);
    chk("ovf_payload", b_if.overflow_error_data[7:0], 8'h3C);
    chk("ovf_level", b_if.level, 1000);
    chk("ovf_sticky", b_if.ovf_err_sticky, 1);
    step();
    chk("ovf_pulse_end", b_if.overflow_error, 0);

    // reset mid-stream overrides write/flush/err_clear
    reset = 1; b_if.write = 1; b_if.flush = 1; b_if.err_clear = 1;
    step();
    reset = 0; b_if.write = 0; b_if.flush = 0; b_if.err_clear = 0;
    chk("mrst_level", b_if.level, 0);
    chk("mrst_empty", b_if.empty, 1);
    chk("mrst_full", b_if.full, 0);
    chk("mrst_rto", b_if.rto_out, 0);
    chk("mrst_ts_data", b_if.timestamp_error_data, 0);
    chk("mrst_ovf_data", b_if.overflow_error_data, 0);
    chk("mrst_ts_sticky", b_if.ts_err_sticky, 0);
    chk("mrst_ovf_sticky", b_if.ovf_err_sticky, 0);
    chk("mrst_late", b_if.late_count, 0);
    chk("mrst_pulses", {b_if.counter_matched, b_if.timestamp_error, b_if.overflow_error}, 0);

    // small instance: 20 entries streamed through depth 8 with wrap
    s_if.auto_start = 1; s_if.counter = 9;
    for (int i = 0; i < 5; i++) begin
      s_if.fifo_din = mk(64'(10 + i), 8'(i * 7 + 1)); s_if.write = 1;
      exp_q.push_back(s_if.fifo_din);
      step();
    end
    s_if.write = 0;
    chk("sm_level5", s_if.level, 5);
    chk("sm_full5", s_if.full, 0);
    for (int k = 0; k < 20; k++) begin
      s_if.counter = 64'(10 + k);
      if (k < 15) begin
        s_if.fifo_din = mk(64'(15 + k), 8'((5 + k) * 7 + 1)); s_if.write = 1;
        exp_q.push_back(s_if.fifo_din);
      end else begin
        s_if.write = 0;
      end
      step();
      chk("sm_match", s_if.counter_matched, 1);
      chk("sm_rto", s_if.rto_out, exp_q.pop_front());
      chk("sm_no_late", s_if.timestamp_error, 0);
    end
    s_if.write = 0;
    chk("sm_q_drained", exp_q.size(), 0);
    chk("sm_end_level", s_if.level, 0);
    chk("sm_end_empty", s_if.empty, 1);
    chk("sm_ts_sticky", s_if.ts_err_sticky, 0);
    chk("sm_ovf_sticky", s_if.ovf_err_sticky, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
